// File: rtl/muldiv_if.sv
// Request/response bundle between the integer multiply/divide unit and its issuer.
// Signal names are from the unit's point of view: *_i are driven into it and *_o come back out.
interface muldiv_if #(
  parameter int Xlen = 64
);
  logic            valid_i;
  logic            ready_o;
  logic [2:0]      funct3_i;
  logic            op32_i;
  logic [Xlen-1:0] a_i;
  logic [Xlen-1:0] b_i;
  logic            kill_i;
  logic            valid_o;
  logic            ready_i;
  logic [Xlen-1:0] res_o;

  modport slave (
    input  valid_i, funct3_i, op32_i, a_i, b_i, kill_i, ready_i,
    output ready_o, valid_o, res_o
  );

  modport master (
    output valid_i, funct3_i, op32_i, a_i, b_i, kill_i, ready_i,
    input  ready_o, valid_o, res_o
  );
endinterface

// File: rtl/muldiv.sv
// Iterative RV M-extension unit: radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Result after N cycles (1 for divide-by-zero/overflow); the result is held in Done until ready_i; kill_i aborts.
module muldiv #(
  parameter int Xlen = 64
) (
  input  logic     clk_i,
  input  logic     rst_i,
  muldiv_if.slave  bus
);
  localparam int CW = 7;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  typedef struct packed {
    logic [2:0] fn;
    logic       w;
    logic       neg;
    logic       neg_rem;
    logic       dz;
    logic       ovf;
  } ctl_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  ctl_t              ctl, ctl_in;
  logic [Xlen-1:0]   opa, opb_mag;
  logic [2*Xlen-1:0] prod;
  logic [Xlen-1:0]   quo, rem;
  logic [Xlen-1:0]   res, res_nxt;

  function automatic logic [Xlen-1:0] fin(input logic [Xlen-1:0] x, input logic w);
    fin = w ? Xlen'(signed'(x[31:0])) : x;
  endfunction

  // Operand decode at accept: width-extend, pick signedness, take magnitudes.
  logic            op32_eff, is_div, a_sgn, b_sgn, sa, sb, accept;
  logic [Xlen-1:0] a_x, b_x, a_mag, b_mag, min_n;

  always_comb begin
    op32_eff = (Xlen == 64) && bus.op32_i;
    is_div   = bus.funct3_i[2];
    a_sgn    = bus.funct3_i inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6};
    b_sgn    = bus.funct3_i inside {3'd0, 3'd1, 3'd4, 3'd6};
    if (op32_eff) begin
      a_x   = a_sgn ? Xlen'(signed'(bus.a_i[31:0])) : Xlen'(bus.a_i[31:0]);
      b_x   = b_sgn ? Xlen'(signed'(bus.b_i[31:0])) : Xlen'(bus.b_i[31:0]);
      min_n = Xlen'(signed'(32'h8000_0000));
    end else begin
      a_x   = bus.a_i;
      b_x   = bus.b_i;
      min_n = {1'b1, {(Xlen-1){1'b0}}};
    end
    sa    = a_sgn & a_x[Xlen-1];
    sb    = b_sgn & b_x[Xlen-1];
    a_mag = sa ? -a_x : a_x;
    b_mag = sb ? -b_x : b_x;

    ctl_in.fn      = bus.funct3_i;
    ctl_in.w       = op32_eff;
    ctl_in.neg     = sa ^ sb;
    ctl_in.neg_rem = sa;
    ctl_in.dz      = is_div && (b_x == '0);
    ctl_in.ovf     = is_div && !bus.funct3_i[0] && (a_x == min_n) && (b_x == '1);
  end

  assign accept = (state == IDLE) && bus.valid_i;

  // One iteration of each datapath plus the sign-corrected results it would produce.
  logic [Xlen:0]     add_sum, r_sh, r_sub;
  logic [2*Xlen-1:0] prod_step, prod_al, prod_sc;
  logic [Xlen-1:0]   quo_step, r_step, q_sc, r_sc, mul_res, div_res, spc_res;
  logic              ge;

  always_comb begin
    add_sum   = {1'b0, prod[2*Xlen-1:Xlen]} + (prod[0] ? {1'b0, opb_mag} : '0);
    prod_step = {add_sum, prod[Xlen-1:1]};
    // After 32 steps of a 64-bit shifter the 32x32 product sits 32 bits up.
    prod_al   = ctl.w ? (prod_step >> 32) : prod_step;
    prod_sc   = ctl.neg ? -prod_al : prod_al;
    mul_res   = (ctl.fn[1:0] == 2'd0) ? prod_sc[Xlen-1:0] : prod_sc[2*Xlen-1:Xlen];

    r_sh     = {rem, quo[Xlen-1]};
    r_sub    = r_sh - {1'b0, opb_mag};
    ge       = ~r_sub[Xlen];
    r_step   = ge ? r_sub[Xlen-1:0] : r_sh[Xlen-1:0];
    quo_step = {quo[Xlen-2:0], ge};
    q_sc     = ctl.neg ? -quo_step : quo_step;
    r_sc     = ctl.neg_rem ? -r_step : r_step;
    div_res  = ctl.fn[1] ? r_sc : q_sc;

    if (ctl.dz) spc_res = ctl.fn[1] ? opa : '1;
    else        spc_res = ctl.fn[1] ? '0  : opa;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    res_nxt   = res;
    case (state)
      IDLE: begin
        if (bus.valid_i) begin
          state_nxt = is_div ? DIV : MUL;
          cnt_nxt   = op32_eff ? CW'(32) : CW'(Xlen);
        end
      end
      MUL: begin
        if (bus.kill_i) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CW'(1)) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
          res_nxt   = fin(mul_res, ctl.w);
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      DIV: begin
        if (bus.kill_i) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (ctl.dz || ctl.ovf) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
          res_nxt   = fin(spc_res, ctl.w);
        end else if (cnt == CW'(1)) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
          res_nxt   = fin(div_res, ctl.w);
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      DONE: begin
        if (bus.kill_i || bus.ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctl     <= '0;
      opa     <= '0;
      opb_mag <= '0;
      prod    <= '0;
      quo     <= '0;
      rem     <= '0;
      res     <= '0;
    end else begin
      if (accept) begin
        ctl     <= ctl_in;
        opa     <= a_x;
        opb_mag <= b_mag;
        prod    <= {{Xlen{1'b0}}, a_mag};
        // Left-align a 32-bit dividend so its MSB is shifted out first.
        quo     <= op32_eff ? (a_mag << (Xlen-32)) : a_mag;
        rem     <= '0;
      end else if (state == MUL) begin
        prod <= prod_step;
      end else if (state == DIV) begin
        quo <= quo_step;
        rem <= r_step;
      end
      res <= res_nxt;
    end
  end

  assign bus.ready_o = (state == IDLE);
  assign bus.valid_o = (state == DONE);
  assign bus.res_o   = res;
endmodule

// File: doc/muldiv.md
MULDIV -- requirements
Module: muldiv

Interface
REQ-001 Parameter Xlen, default 64, is the datapath width; legal values are 32 and 64.
REQ-002 Port clk_i, input, 1 bit, is the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_i, input, 1 bit, is the reset; it SHALL be asynchronous and active-high.
REQ-004 Port valid_i, input, 1 bit, means a request is offered.
REQ-005 Port ready_o, output, 1 bit, means the unit can accept a request.
REQ-006 Port funct3_i, input, 3 bits, selects the operation: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 Port op32_i, input, 1 bit, selects the W variant; it SHALL be ignored (treated as 0) when Xlen=32.
REQ-008 Ports a_i and b_i, input, Xlen bits each, are operand rs1 and operand rs2.
REQ-009 Port kill_i, input, 1 bit, aborts the in-flight operation.
REQ-010 Port valid_o, output, 1 bit, means res_o holds a result.
REQ-011 Port ready_i, input, 1 bit, means the consumer accepts the result.
REQ-012 Port res_o, output, Xlen bits, is the registered result.

Function
REQ-013 FSM states SHALL be Idle, Mul, Div and Done; ready_o=1 only in Idle, and valid_o=1 only in Done.
REQ-014 Accept SHALL occur when valid_i&&ready_o at an edge; funct3_i, op32_i, a_i and b_i are latched at that edge, and later input changes SHALL be ignored.
REQ-015 After accept, funct3_i<4 SHALL go to Mul and funct3_i>=4 SHALL go to Div, with an iteration counter N set as follows: N=32 if op32_i, otherwise N=Xlen.
REQ-016 Mul and Div SHALL process one bit per cycle (radix-2 shift-add multiply, restoring divide) on operand magnitudes; after exactly N edges in Mul or Div the FSM SHALL enter Done, so valid_o is first high after edge N counted from accept edge 0.
REQ-017 Signedness: MUL, MULH, DIV and REM treat both operands as signed; MULHSU treats a as signed and b as unsigned; MULHU, DIVU and REMU treat both operands as unsigned.
REQ-018 Final sign correction SHALL be applied when the result register is written: the product is negated if the operand signs differ; the quotient is negated if the operand signs differ; the remainder takes the dividend's sign.
REQ-019 MUL SHALL return the low N bits of the 2N-bit product; MULH, MULHSU and MULHU SHALL return the high N bits.
REQ-020 W variants (op32_i=1, Xlen=64) SHALL use a[31:0] and b[31:0], take the sign from bit 31, and sign-extend the 32-bit result from bit 31 to Xlen; only MUL, DIV, DIVU, REM and REMU are legal with op32_i, and other funct3_i values give an undefined res_o.
REQ-021 Divide by zero SHALL give a quotient of all ones (width N, then sign-extended for W) and a remainder equal to the dividend; it SHALL bypass Div and enter Done after edge 1.
REQ-022 Signed overflow (dividend = most-negative N-bit value, divisor = -1) SHALL give quotient = dividend and remainder = 0; it SHALL enter Done after edge 1.
REQ-023 In Done, res_o and valid_o SHALL hold until ready_i=1; at the edge where valid_o&&ready_i, the FSM SHALL go to Idle; the unit SHALL NOT accept a new request in the same cycle.
REQ-024 kill_i=1 in Mul, Div or Done SHALL force Idle at the next edge with valid_o=0 after that edge; kill_i in Idle SHALL have no effect, and kill_i SHALL take priority over accept and over completion.
REQ-025 res_o SHALL be written only on entry to Done; its value outside Done is don't-care.

Reset
REQ-026 While rst_i=1, independent of clk_i, the state SHALL be Idle, valid_o=0, ready_o=1, res_o=0 and the counter=0.
REQ-027 Reset asserted mid-operation SHALL discard the operation, and no valid_o SHALL follow.

Verification
REQ-028 Xlen=64, MUL a=7, b=-3 -> res_o=-21 (0xFFFFFFFFFFFFFFEB), valid_o first high 64 edges after accept.
REQ-029 Xlen=64, MULHU a=b=0xFFFFFFFFFFFFFFFF -> res_o=0xFFFFFFFFFFFFFFFE; MULHSU a=-1, b=2 -> res_o=0xFFFFFFFFFFFFFFFF.
REQ-030 DIV a=-7, b=2 -> quotient -3; REM same operands -> -1; DIVW a=0x0000000080000000, b=-1 -> res_o=0xFFFFFFFF80000000 after 1 edge.
REQ-031 DIVU a=5, b=0 -> res_o all ones after 1 edge; REMU a=5, b=0 -> res_o=5.
REQ-032 Backpressure: hold ready_i=0 for 10 cycles in Done -> res_o and valid_o stable and ready_o=0; then ready_i=1 -> Idle next edge.
REQ-033 kill_i pulsed 5 cycles into Div, then a new MUL 3*4 issued -> no valid_o for the killed operation, res_o=12 for the new one; rst_i pulsed mid-Mul -> outputs at reset values immediately.
